d_latch_active_clrn: RTL and testbench
======================================

Name: d_latch_active_clrn

Overview:
- Clocked, WIDTH-bit emulation of a gated D latch with an active-low clear.
- While gate G is high, Q follows D. While G is low, Q holds its value. CLRn low forces Q to 0.
- All inputs are treated as level signals and sampled on clk, with optional synchronizer stages, so the block can sit in a fully synchronous design.
- Also provides gate open/close pulses, a clear-active status flag, and a saturating count of transparent update cycles for debug.

Parameters:
- WIDTH, 1, bit width of D and Q.
- SYNC_STAGES, 0, flop stages (0..3) in front of the core on CLRn, G and D; 0 means inputs feed the core directly.
- CNT_W, 8, width of the saturating update counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  one clock; reset is synchronous and active-high.
- CLRn  input  1  active-low clear; level-sensitive; sampled on clk.
- D  input  WIDTH  latch data.
- G  input  1  latch gate/enable, active high; level input, not a clock.
- Q  output  WIDTH  latch output, registered.
- clr_active  output  1  high while the sampled CLRn is 0.
- g_open  output  1  one-cycle pulse on a sampled G 0->1 transition.
- g_close  output  1  one-cycle pulse on a sampled G 1->0 transition.
- upd_cnt  output  CNT_W  saturating count of cycles in which Q was loaded from D.

Behaviour:
- Input path:
  - CLRn, G and D each pass through SYNC_STAGES flops, giving clrn_s, g_s and d_s.
  - Synchronizer flops reset to CLRn=1, G=0, D=0.
- Core priority, evaluated on each rising clk edge, highest first:
  1. rst=1: Q<=0, upd_cnt<=0, clr_active<=0, g_open<=0, g_close<=0, g_prev<=0, synchronizer flops to their reset values.
  2. clrn_s=0: Q<=0; G and D are ignored; upd_cnt unchanged.
  3. g_s=1: Q<=d_s (transparent); upd_cnt<=upd_cnt+1, saturating at all-ones.
  4. Otherwise: Q holds (opaque).
- Latency:
  - An input level change is visible on Q SYNC_STAGES+1 rising edges later.
  - With SYNC_STAGES=0, that is the next edge.
- Transparent window: D changes while g_s=1 propagate every cycle. The value held after close is d_s from the last cycle in which g_s=1.
- Clear release: when CLRn returns to 1 with g_s=0, Q stays 0 until the next transparent cycle.
- Simultaneous CLRn=0 and G=1: clear wins and Q=0.
- clr_active is registered: clr_active<=~clrn_s. It is 0 during and right after rst.
- Gate-edge pulses:
  - g_prev is a registered copy of g_s.
  - g_open<=g_s&~g_prev; g_close<=~g_s&g_prev.
  - Each pulse lasts exactly one cycle and is generated regardless of CLRn.
- upd_cnt:
  - Increments only in priority-3 cycles; stops at 2^CNT_W-1.
  - Cleared only by rst.
- Reset mid-operation: rst overrides everything in the same edge. The first post-reset cycle behaves as if G=0 and CLRn=1 were previously sampled.
- No X-propagation: all registers have defined reset values. Q never changes except on clk.

Test Plan:
- Reset: hold rst=1 for 2 cycles with D=1, G=1, CLRn=1 -> Q=0, upd_cnt=0, no pulses. Release -> Q=1 on the next edge (SYNC_STAGES=0).
- Clear dominance: CLRn=0, D=1, G toggling every cycle for 4 cycles -> Q=0 throughout, clr_active=1, upd_cnt unchanged, g_open/g_close still pulse.
- Transparent/hold: CLRn=1, G=1, D=1 -> Q=1. Drop G=0, then D=0 -> Q stays 1. Raise G=1 -> Q=0 next edge, and the counter increments once per G=1 cycle.
- Clear release while opaque: Q=1, G=0, pulse CLRn=0 for 1 cycle then 1 -> Q=0 and remains 0 until G=1 with D=1, then Q=1.
- Random: 20 iterations of random D/CLRn each held 5 cycles, G toggling every cycle -> Q matches the reference model (priority rst>CLRn>G) every cycle.
- Latency/saturation: SYNC_STAGES=2, step D with G=1 -> Q changes 3 edges later. CNT_W=4 with G=1 for 20 cycles -> upd_cnt=15 and stays 15.

Source files
------------

// File: rtl/d_latch_active_clrn.sv
// Clocked emulation of a gated D latch with active-low clear, optional input
// synchronizers, gate-edge pulses and a saturating transparent-cycle counter.
module d_latch_active_clrn #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CLRn,
    input  logic [WIDTH-1:0] D,
    input  logic             G,
    output logic [WIDTH-1:0] Q,
    output logic             clr_active,
    output logic             g_open,
    output logic             g_close,
    output logic [CNT_W-1:0] upd_cnt
);

    logic             clrn_s;
    logic             g_s;
    logic [WIDTH-1:0] d_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign clrn_s = CLRn;
            assign g_s    = G;
            assign d_s    = D;
        end else begin : g_sync
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                logic             clrn_q;
                logic             g_q;
                logic [WIDTH-1:0] d_q;
                logic             clrn_in;
                logic             g_in;
                logic [WIDTH-1:0] d_in;

                if (gi == 0) begin : g_first
                    assign clrn_in = CLRn;
                    assign g_in    = G;
                    assign d_in    = D;
                end else begin : g_chain
                    assign clrn_in = g_stage[gi-1].clrn_q;
                    assign g_in    = g_stage[gi-1].g_q;
                    assign d_in    = g_stage[gi-1].d_q;
                end

                // Reset to "not cleared, gate closed" so release looks like a quiet past.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        clrn_q <= 1'b1;
                        g_q    <= 1'b0;
                        d_q    <= '0;
                    end else begin
                        clrn_q <= clrn_in;
                        g_q    <= g_in;
                        d_q    <= d_in;
                    end
                end
            end
            assign clrn_s = g_stage[SYNC_STAGES-1].clrn_q;
            assign g_s    = g_stage[SYNC_STAGES-1].g_q;
            assign d_s    = g_stage[SYNC_STAGES-1].d_q;
        end
    endgenerate

    logic [WIDTH-1:0] q_q,     q_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             clr_q,   clr_d;
    logic             open_q,  open_d;
    logic             close_q, close_d;
    logic             gprev_q, gprev_d;

    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        clr_d   = ~clrn_s;
        gprev_d = g_s;
        open_d  = g_s & ~gprev_q;
        close_d = ~g_s & gprev_q;
        // Clear dominates the gate; the counter only tracks real loads from D.
        if (!clrn_s) begin
            q_d = '0;
        end else if (g_s) begin
            q_d = d_s;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            open_q  <= 1'b0;
            close_q <= 1'b0;
            gprev_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            open_q  <= open_d;
            close_q <= close_d;
            gprev_q <= gprev_d;
        end
    end

    assign Q          = q_q;
    assign upd_cnt    = cnt_q;
    assign clr_active = clr_q;
    assign g_open     = open_q;
    assign g_close    = close_q;

endmodule

// File: tb/tb_d_latch_active_clrn.sv
// Directed and randomized checks of d_latch_active_clrn: a direct-input instance
// and a 2-stage-synchronized instance with a 4-bit counter share the stimulus.
module tb_d_latch_active_clrn;

    logic       clk = 1'b0;
    logic       rst;
    logic       CLRn;
    logic [3:0] D;
    logic       G;

    logic [3:0] q0, q2;
    logic       clr0, clr2, open0, open2, close0, close2;
    logic [7:0] cnt0;
    logic [3:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state for the direct-input instance
    logic [3:0] m_q;
    logic [7:0] m_cnt;
    logic       m_clr, m_open, m_close, m_gprev;

    always #5 clk = ~clk;

    d_latch_active_clrn #(.WIDTH(4), .SYNC_STAGES(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .CLRn(CLRn), .D(D), .G(G),
        .Q(q0), .clr_active(clr0), .g_open(open0), .g_close(close0), .upd_cnt(cnt0)
    );

    d_latch_active_clrn #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .CLRn(CLRn), .D(D), .G(G),
        .Q(q2), .clr_active(clr2), .g_open(open2), .g_close(close2), .upd_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance the reference one edge using the currently driven inputs, then
    // let the DUT take the same edge and settle.
    task automatic tick();
        if (rst) begin
            m_q = '0; m_cnt = '0; m_clr = 1'b0;
            m_open = 1'b0; m_close = 1'b0; m_gprev = 1'b0;
        end else begin
            m_clr   = ~CLRn;
            m_open  = G & ~m_gprev;
            m_close = ~G & m_gprev;
            m_gprev = G;
            if (!CLRn) m_q = '0;
            else if (G) begin
                m_q = D;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".Q"},     32'(q0),     32'(m_q));
        chk({tag, ".cnt"},   32'(cnt0),   32'(m_cnt));
        chk({tag, ".clr"},   32'(clr0),   32'(m_clr));
        chk({tag, ".open"},  32'(open0),  32'(m_open));
        chk({tag, ".close"}, 32'(close0), 32'(m_close));
    endtask

    initial begin
        rst = 1'b1; D = 4'd1; G = 1'b1; CLRn = 1'b1;
        m_q = '0; m_cnt = '0; m_clr = 1'b0; m_open = 1'b0; m_close = 1'b0; m_gprev = 1'b0;

        // Reset held two cycles with the latch otherwise transparent
        tick(); tick();
        chk("rst.Q",     32'(q0),     32'd0);
        chk("rst.cnt",   32'(cnt0),   32'd0);
        chk("rst.open",  32'(open0),  32'd0);
        chk("rst.close", 32'(close0), 32'd0);
        chk("rst.clr",   32'(clr0),   32'd0);
        rst = 1'b0;
        tick();
        chk("rel.Q",    32'(q0),    32'd1);
        chk("rel.cnt",  32'(cnt0),  32'd1);
        chk("rel.open", 32'(open0), 32'd1);

        // Clear dominates while G toggles; pulses still fire
        CLRn = 1'b0; D = 4'd1;
        for (int i = 0; i < 4; i++) begin
            G = i[0];
            tick();
            chk("clr.Q",   32'(q0),   32'd0);
            chk("clr.clr", 32'(clr0), 32'd1);
            if (i[0]) chk("clr.open",  32'(open0),  32'd1);
            else      chk("clr.close", 32'(close0), 32'd1);
        end
        chk("clr.cnt", 32'(cnt0), 32'd1);

        // Transparent / hold
        CLRn = 1'b1; G = 1'b1; D = 4'd1;
        tick();
        chk("th.Q1",   32'(q0),   32'd1);
        chk("th.cnt1", 32'(cnt0), 32'd2);
        chk("th.clr",  32'(clr0), 32'd0);
        G = 1'b0;
        tick();
        chk("th.hold1", 32'(q0),     32'd1);
        chk("th.close", 32'(close0), 32'd1);
        D = 4'd0;
        tick();
        chk("th.hold2",   32'(q0),   32'd1);
        chk("th.cnthold", 32'(cnt0), 32'd2);
        G = 1'b1;
        tick();
        chk("th.Q0",   32'(q0),    32'd0);
        chk("th.cnt3", 32'(cnt0),  32'd3);
        chk("th.open", 32'(open0), 32'd1);
        tick();
        chk("th.cnt4", 32'(cnt0), 32'd4);

        // Clear release while opaque
        D = 4'd1;
        tick();
        chk("cr.Q1", 32'(q0), 32'd1);
        G = 1'b0;
        tick();
        CLRn = 1'b0;
        tick();
        chk("cr.cleared", 32'(q0), 32'd0);
        CLRn = 1'b1;
        tick();
        chk("cr.stay0a", 32'(q0),   32'd0);
        chk("cr.clroff", 32'(clr0), 32'd0);
        tick();
        chk("cr.stay0b", 32'(q0), 32'd0);
        G = 1'b1;
        tick();
        chk("cr.load", 32'(q0),   32'd1);
        chk("cr.cnt",  32'(cnt0), 32'd6);

        // Mid-operation reset with the gate open
        D = 4'd5; rst = 1'b1;
        tick();
        chk("mr.Q",   32'(q0),   32'd0);
        chk("mr.cnt", 32'(cnt0), 32'd0);
        rst = 1'b0;
        tick();
        chk("mr.Q5",   32'(q0),    32'd5);
        chk("mr.open", 32'(open0), 32'd1);

        // Random data/clear held 5 cycles, gate toggling every cycle
        for (int it = 0; it < 20; it++) begin
            D    = 4'($urandom_range(0, 15));
            CLRn = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 5; c++) begin
                G = ~G;
                tick();
                chk_model("rnd");
            end
        end

        // Synchronized instance: latency and counter saturation
        rst = 1'b1; G = 1'b1; CLRn = 1'b1; D = 4'd0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("lat.base", 32'(q2), 32'd0);
        D = 4'd1;
        tick();
        chk("lat.e1", 32'(q2), 32'd0);
        tick();
        chk("lat.e2", 32'(q2), 32'd0);
        tick();
        chk("lat.e3", 32'(q2), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("sat.cnt15", 32'(cnt2), 32'd15);
        for (int i = 0; i < 3; i++) tick();
        chk("sat.hold", 32'(cnt2), 32'd15);
        chk_model("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
